// File: rtl/lpc_coeff_bank_pkg.sv
// Shared sizes, FSM state type and order check for the LPC coefficient bank.
// The optional precision-shift path is enabled by defining LPC_COEFF_SHIFT_EN.
package lpc_coeff_bank_pkg;

   localparam int COEFF_W   = 12;
   localparam int MAX_ORDER = 12;
   localparam int ORDER_W   = 4;
   localparam int SHIFT_W   = 5;

   localparam logic [ORDER_W-1:0] MAX_TAP = ORDER_W'(MAX_ORDER);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WAIT
   } state_t;

   function automatic logic order_legal(input logic [ORDER_W-1:0] order);
      return (order != '0) && (order <= MAX_TAP);
   endfunction

endpackage

// File: rtl/lpc_coeff_regfile.sv
// One coefficient bank: whole-bank clear, indexed write, registered indexed read.
// The read sees a same-edge clear or write so a freshly published bank reads correctly.
module lpc_coeff_regfile
   import lpc_coeff_bank_pkg::*;
(
   input  logic               iClock,
   input  logic               iReset,
   input  logic               iEnable,
   input  logic               iClear,
   input  logic               iWrite,
   input  logic [ORDER_W-1:0] iAddr,
   input  logic [COEFF_W-1:0] iData,
   input  logic [ORDER_W-1:0] iRdAddr,
   output logic [COEFF_W-1:0] oRdData
);

   logic [COEFF_W-1:0] mem [MAX_ORDER];

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         // NOTE: the bank storage is reset because the filter must read zeros before any frame arrives.
         for (int i = 0; i < MAX_ORDER; i++) mem[i] <= '0;
         oRdData <= '0;
      end else if (iEnable) begin
         if (iClear) begin
            for (int i = 0; i < MAX_ORDER; i++) mem[i] <= '0;
         end else if (iWrite && (iAddr < MAX_TAP)) begin
            mem[iAddr] <= iData;
         end

         if (iClear || (iRdAddr >= MAX_TAP)) oRdData <= '0;
         else if (iWrite && (iAddr == iRdAddr)) oRdData <= iData;
         else oRdData <= mem[iRdAddr];
      end
   end

endmodule

// File: rtl/lpc_coeff_bank.sv
// Double-buffered LPC coefficient bank: collects a tap stream, publishes it for filter reads.
// Define LPC_COEFF_SHIFT_EN to add the iShift/oShift precision-shift ports.
module lpc_coeff_bank
   import lpc_coeff_bank_pkg::*;
(
   input  logic               iClock,
   input  logic               iReset,
   input  logic               iEnable,
   input  logic               iStart,
   input  logic [ORDER_W-1:0] iOrder,
   input  logic [COEFF_W-1:0] iCoeff,
   input  logic               iValid,
   input  logic               iRelease,
   input  logic [ORDER_W-1:0] iTap,
   output logic [COEFF_W-1:0] oTapCoeff,
   output logic [ORDER_W-1:0] oOrder,
   output logic               oReady,
   output logic               oBusy,
`ifdef LPC_COEFF_SHIFT_EN
   output logic               oError,
   input  logic [SHIFT_W-1:0] iShift,
   output logic [SHIFT_W-1:0] oShift
`else
   output logic               oError
`endif
);

   state_t             state_q, state_d;
   logic [ORDER_W-1:0] count_q, count_d;
   logic [ORDER_W-1:0] order_q, order_d, order_pub_d;
   logic               sel_q, sel_d;
   logic               ready_d, error_d;
   logic               start_ok, take_start, swap, wr_en, clr;
   logic [COEFF_W-1:0] rd0, rd1;

   assign start_ok = iStart && order_legal(iOrder);

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      count_d     = count_q;
      order_d     = order_q;
      order_pub_d = oOrder;
      sel_d       = sel_q;
      ready_d     = oReady;
      error_d     = oError;
      take_start  = 1'b0;
      swap        = 1'b0;
      wr_en       = 1'b0;
      clr         = 1'b0;

      if (iStart && !start_ok) error_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (iValid)   error_d = 1'b1;
            if (iRelease) ready_d = 1'b0;
            if (start_ok) take_start = 1'b1;
         end
         COLLECT: begin
            if (iRelease) ready_d = 1'b0;
            if (start_ok) begin
               take_start = 1'b1;
               error_d    = 1'b1;
            end else if (iValid) begin
               wr_en   = 1'b1;
               count_d = count_q + ORDER_W'(1);
               if (count_d == order_q) begin
                  if (!oReady || iRelease) swap = 1'b1;
                  else state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (iStart || iValid) error_d = 1'b1;
            if (iRelease)         swap    = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (take_start) begin
         order_d = iOrder;
         count_d = '0;
         clr     = 1'b1;
         state_d = COLLECT;
      end

      // Publishing flips which bank the filter reads; the old read bank becomes the write bank.
      if (swap) begin
         sel_d       = ~sel_q;
         ready_d     = 1'b1;
         order_pub_d = order_q;
         state_d     = IDLE;
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q <= IDLE;
         count_q <= '0;
         order_q <= '0;
         sel_q   <= 1'b0;
         oOrder  <= '0;
         oReady  <= 1'b0;
         oError  <= 1'b0;
      end else if (iEnable) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         count_q <= count_d;
         order_q <= order_d;
         sel_q   <= sel_d;
         oOrder  <= order_pub_d;
         oReady  <= ready_d;
         oError  <= error_d;
      end
   end

`ifdef LPC_COEFF_SHIFT_EN
   logic [SHIFT_W-1:0] shift_q;

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         shift_q <= '0;
         oShift  <= '0;
      end else if (iEnable) begin
         if (take_start) shift_q <= iShift;
         if (swap)       oShift  <= shift_q;
      end
   end
`endif

   // sel_q selects the read bank; the other bank collects.
   lpc_coeff_regfile u_bank0 (
      .iClock  (iClock),
      .iReset  (iReset),
      .iEnable (iEnable),
      .iClear  (clr && sel_q),
      .iWrite  (wr_en && sel_q),
      .iAddr   (count_q),
      .iData   (iCoeff),
      .iRdAddr (iTap),
      .oRdData (rd0)
   );

   lpc_coeff_regfile u_bank1 (
      .iClock  (iClock),
      .iReset  (iReset),
      .iEnable (iEnable),
      .iClear  (clr && !sel_q),
      .iWrite  (wr_en && !sel_q),
      .iAddr   (count_q),
      .iData   (iCoeff),
      .iRdAddr (iTap),
      .oRdData (rd1)
   );

   assign oTapCoeff = sel_q ? rd1 : rd0;
   assign oBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_lpc_coeff_bank.sv
// Self-checking bench for lpc_coeff_bank: directed scenarios then random traffic vs a queue model.
// Compile with LPC_COEFF_SHIFT_EN defined to also exercise the iShift/oShift path.
module tb_lpc_coeff_bank;
   import lpc_coeff_bank_pkg::*;

   logic               iClock = 1'b0;
   logic               iReset = 1'b0;
   logic               iEnable = 1'b0;
   logic               iStart = 1'b0;
   logic [ORDER_W-1:0] iOrder = '0;
   logic [COEFF_W-1:0] iCoeff = '0;
   logic               iValid = 1'b0;
   logic               iRelease = 1'b0;
   logic [ORDER_W-1:0] iTap = '0;
   logic [COEFF_W-1:0] oTapCoeff;
   logic [ORDER_W-1:0] oOrder;
   logic               oReady, oBusy, oError;
`ifdef LPC_COEFF_SHIFT_EN
   logic [SHIFT_W-1:0] iShift = '0;
   logic [SHIFT_W-1:0] oShift;
`endif

   lpc_coeff_bank dut (
      .iClock    (iClock),
      .iReset    (iReset),
      .iEnable   (iEnable),
      .iStart    (iStart),
      .iOrder    (iOrder),
      .iCoeff    (iCoeff),
      .iValid    (iValid),
      .iRelease  (iRelease),
      .iTap      (iTap),
      .oTapCoeff (oTapCoeff),
      .oOrder    (oOrder),
      .oReady    (oReady),
      .oBusy     (oBusy),
`ifdef LPC_COEFF_SHIFT_EN
      .oError    (oError),
      .iShift    (iShift),
      .oShift    (oShift)
`else
      .oError    (oError)
`endif
   );

   always #5 iClock = ~iClock;

   int    n_checks = 0;
   int    n_fail   = 0;
   string phase    = "reset";

   // Reference model: published set as an array, frame in progress as a queue.
   int m_rd [MAX_ORDER];
   int m_q [$];
   int m_word, m_pub_order, m_tap, m_shift, m_pub_shift;
   bit m_collecting, m_pending, m_ready, m_err;

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_rd[i]) m_rd[i] = 0;
      m_q.delete();
      m_word = 0; m_pub_order = 0; m_tap = 0; m_shift = 0; m_pub_shift = 0;
      m_collecting = 0; m_pending = 0; m_ready = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit legal, publish;
      int ord, cf;
      ord     = int'(iOrder);
      cf      = int'($signed(iCoeff));
      legal   = iStart && (ord >= 1) && (ord <= MAX_ORDER);
      publish = 0;
      if (iStart && !legal) m_err = 1;
      if (m_pending) begin
         if (iStart || iValid) m_err = 1;
         if (iRelease) publish = 1;
      end else if (m_collecting) begin
         if (legal) begin
            m_err = 1;
            m_q.delete();
            m_word = ord;
`ifdef LPC_COEFF_SHIFT_EN
            m_shift = int'($signed(iShift));
`endif
         end else if (iValid) begin
            m_q.push_back(cf);
            if (m_q.size() == m_word) begin
               if (!m_ready || iRelease) publish = 1;
               else begin
                  m_collecting = 0;
                  m_pending    = 1;
               end
            end
         end
         if (iRelease && !publish) m_ready = 0;
      end else begin
         if (iValid)   m_err = 1;
         if (iRelease) m_ready = 0;
         if (legal) begin
            m_collecting = 1;
            m_q.delete();
            m_word = ord;
`ifdef LPC_COEFF_SHIFT_EN
            m_shift = int'($signed(iShift));
`endif
         end
      end
      if (publish) begin
         for (int i = 0; i < MAX_ORDER; i++) m_rd[i] = (i < m_q.size()) ? m_q[i] : 0;
         m_pub_order  = m_word;
         m_pub_shift  = m_shift;
         m_ready      = 1;
         m_collecting = 0;
         m_pending    = 0;
      end
      m_tap = (int'(iTap) < MAX_ORDER) ? m_rd[int'(iTap)] : 0;
   endtask

   task automatic check_outputs();
      check({phase, "/tap"},   $signed(oTapCoeff), m_tap);
      check({phase, "/order"}, {28'd0, oOrder},    m_pub_order);
      check({phase, "/ready"}, {31'd0, oReady},    {31'd0, m_ready});
      check({phase, "/busy"},  {31'd0, oBusy},     {31'd0, (m_collecting | m_pending)});
      check({phase, "/error"}, {31'd0, oError},    {31'd0, m_err});
`ifdef LPC_COEFF_SHIFT_EN
      check({phase, "/shift"}, $signed(oShift),    m_pub_shift);
`endif
   endtask

   task automatic tick();
      @(posedge iClock);
      if (iEnable && iReset) model_step();
      #1;
      check_outputs();
   endtask

   task automatic drive(input bit st, input int ord, input bit val, input int cf,
                        input bit rel, input int tap, input bit en = 1'b1);
      iStart   = st;
      iOrder   = ORDER_W'(ord);
      iValid   = val;
      iCoeff   = COEFF_W'(cf);
      iRelease = rel;
      iTap     = ORDER_W'(tap);
      iEnable  = en;
      tick();
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset();
      iReset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(posedge iClock);
      #1;
      check_outputs();
      iReset = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();

      phase = "t1_stream";
`ifdef LPC_COEFF_SHIFT_EN
      iShift = 5'b11101;
`endif
      drive(1, 3, 0, 0, 0, 0);
      drive(0, 0, 1, 5, 0, 0);
      drive(0, 0, 1, -7, 0, 0);
      drive(0, 0, 1, 100, 0, 0);
      check("t1_ready_const", {31'd0, oReady}, 1);
      check("t1_order_const", {28'd0, oOrder}, 3);
`ifdef LPC_COEFF_SHIFT_EN
      check("t1_shift_const", $signed(oShift), -3);
`endif
      for (int t = 0; t < 4; t++) drive(0, 0, 0, 0, 0, t);
      check("t1_tap3_const", $signed(oTapCoeff), 0);

      phase = "t2_wait";
      drive(1, 2, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0);
      drive(0, 0, 1, 2, 0, 0);
      check("t2_busy_const", {31'd0, oBusy}, 1);
      drive(0, 0, 0, 0, 0, 1);
      check("t2_old_tap1", $signed(oTapCoeff), -7);
      drive(0, 0, 0, 0, 1, 0);
      check("t2_new_tap0", $signed(oTapCoeff), 1);
      check("t2_order_const", {28'd0, oOrder}, 2);
      drive(0, 0, 0, 0, 0, 1);

      phase = "t3_direct";
      drive(1, 1, 0, 0, 0, 0);
      drive(0, 0, 1, 9, 1, 0);
      check("t3_busy_const", {31'd0, oBusy}, 0);
      check("t3_tap0", $signed(oTapCoeff), 9);
      drive(0, 0, 0, 0, 1, 0);
      check("t3_release_ready", {31'd0, oReady}, 0);

      phase = "t4_errors";
      drive(0, 0, 1, 55, 0, 0);
      check("t4_err_valid_idle", {31'd0, oError}, 1);
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 2, 0, 0, 0, 0);
      drive(0, 0, 1, 11, 0, 0);
      drive(1, 2, 0, 0, 0, 0);
      drive(0, 0, 1, 21, 0, 0);
      drive(0, 0, 1, 22, 0, 0);
      check("t4_restart_tap0", $signed(oTapCoeff), 21);
      drive(0, 0, 0, 0, 0, 1);
      check("t4_restart_tap1", $signed(oTapCoeff), 22);
      check("t4_err_sticky", {31'd0, oError}, 1);

      phase = "t5_enable";
      drive(1, 3, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0);
      repeat (4) drive(0, 0, 1, 99, 0, 0, 0);
      drive(0, 0, 1, 2, 0, 0);
      drive(0, 0, 1, 3, 0, 0);
      drive(0, 0, 0, 0, 1, 1);
      check("t5_tap1", $signed(oTapCoeff), 2);
      drive(0, 0, 0, 0, 0, 2);
      check("t5_tap2", $signed(oTapCoeff), 3);

      phase = "t6_reset";
      drive(1, 4, 0, 0, 0, 0);
      drive(0, 0, 1, 7, 0, 0);
      do_reset();

      phase = "random";
      for (int c = 0; c < 3000; c++) begin
         logic [COEFF_W-1:0] cv;
         cv = COEFF_W'($urandom);
`ifdef LPC_COEFF_SHIFT_EN
         iShift = SHIFT_W'($urandom);
`endif
         if ($urandom_range(0, 499) == 0) do_reset();
         drive($urandom_range(0, 9) == 0, int'($urandom_range(0, 14)),
               $urandom_range(0, 1) == 1, int'($signed(cv)),
               $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
               $urandom_range(0, 9) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lpc_coeff_bank.md
Name: lpc_coeff_bank

Overview:
Consumer end of the quantized-LPC coefficient stream produced by the encoder's coefficient store (serial coeff plus one-cycle valid pulses, one per tap, for the chosen best order).
- Collects the stream into a write bank, then publishes it as a stable read bank with random-access tap reads for the residual/prediction filter.
- Double-buffered: the next frame's coefficients can arrive while the filter still uses the current set.

Parameters:
COEFF_W, 12, signed coefficient width
MAX_ORDER, 12, maximum LPC order (taps per bank)
ORDER_W, 4, width of order and tap index

Ports:
iClock  in  1  clock, rising edge
iReset  in  1  asynchronous, active-low reset
iEnable  in  1  clock enable; when low, all state and outputs hold
iStart  in  1  pulse: begin collecting a frame; latches iOrder
iOrder  in  ORDER_W  tap count expected, legal 1..MAX_ORDER
iCoeff  in  COEFF_W  signed coefficient from store
iValid  in  1  iCoeff valid this cycle
iRelease  in  1  pulse: filter finished with read bank
iTap  in  ORDER_W  read tap index
oTapCoeff  out  COEFF_W  registered read of read-bank tap iTap
oOrder  out  ORDER_W  order of published read bank
oReady  out  1  read bank holds a complete, stable set
oBusy  out  1  collecting (COLLECT or WAIT)
oError  out  1  sticky protocol error flag

Behaviour:
- Reset (iReset=0, async): both banks zero; state IDLE; count 0; oTapCoeff=0, oOrder=0, oReady=0, oBusy=0, oError=0.
- All actions below occur only on cycles with iEnable=1.
- States: IDLE, COLLECT, WAIT.
- IDLE + iStart with legal iOrder:
  - latch order; clear write bank to zero; count=0; go COLLECT.
  - An iValid on the iStart cycle is ignored and sets oError.
- Illegal iOrder (0 or >MAX_ORDER) on iStart: ignore the start, set oError, stay in current state.
- COLLECT + iValid:
  - write iCoeff to write bank[count]; count+1.
  - First received coefficient is tap 0.
- Last coefficient written (count reaches order):
  - If oReady=0, or iRelease is asserted that same cycle: swap banks on the next edge, set oReady=1, oOrder=latched order, go IDLE.
  - Otherwise go WAIT.
- WAIT: hold; on iRelease, swap on the next edge, set oReady=1, go IDLE.
- iRelease with no pending bank: oReady -> 0.
- iRelease while oReady=0: ignored.
- Error handling:
  - iStart in COLLECT: abort; restart with the new order; set oError.
  - iStart in WAIT: ignored; set oError.
  - iValid in IDLE or WAIT: dropped; set oError.
- oBusy=1 in COLLECT and WAIT.
- oTapCoeff: 1-cycle latency; value = read bank[iTap]; 0 if iTap >= MAX_ORDER.
  - Taps >= oOrder read 0 because the write bank is cleared on start.
  - On the swap edge, the next-cycle read reflects the new bank.
- oError clears only on reset.
- Reset mid-collection discards everything.

Optional Feature:
LPC_COEFF_SHIFT_EN
- Defined:
  - adds input iShift (5-bit signed, quantization precision shift), latched on a legal iStart;
  - adds output oShift, published with the bank on swap; reset value 0.
- Undefined: neither port exists; the filter uses a fixed shift supplied elsewhere.

Decomposition:
- Shared package: COEFF_W, MAX_ORDER, ORDER_W, SHIFT_W=5, state enum (IDLE/COLLECT/WAIT).
- Sub-module lpc_coeff_regfile: one bank with clear, indexed write and registered indexed read. Instantiated twice; the top holds the FSM and bank-select bit.

Test Plan:
- Start order=3; stream 5, -7, 100 -> oReady=1, oOrder=3 after the swap; reads of taps 0,1,2,3 give 5, -7, 100, 0 (1-cycle latency).
- Bank A published; collect order=2 (1, 2) without iRelease -> WAIT, oBusy=1, reads still A; pulse iRelease -> next cycle taps 0,1 = 1, 2, oOrder=2.
- Last coeff and iRelease on the same cycle -> direct swap, no WAIT cycle.
- iValid in IDLE, iStart with iOrder=0, iStart mid-COLLECT -> oError=1 and stays 1; aborted collection restarts at tap 0.
- iEnable=0 for 4 cycles mid-stream with iValid=1 -> no writes, count unchanged; resumes correctly.
- Assert iReset during COLLECT -> all outputs 0 immediately; with LPC_COEFF_SHIFT_EN, iShift=-3 latched on start appears on oShift at swap.
